// File: rtl/data_memory_pkg.sv
// Shared encodings and byte-enable helper for the
// byte-addressable MEM-stage data memory.
package data_memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic logic [3:0] byte_enable(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      (size == SIZE_BYTE): be = 4'b0001 << off;
      (size == SIZE_HALF): be = off[1] ? 4'b1100 : 4'b0011;
      (size == SIZE_WORD): be = 4'b1111;
      default:             be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_memory_be_mem_load_align.sv
// Load lane select plus sign/zero extension.
// Purely combinational; the caller registers the result.
module mem_load_align
  import data_memory_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        unsignedLoad,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    unique case (off)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    unique case (1'b1)
      (size == SIZE_BYTE):
        result = {{24{b[7] & ~unsignedLoad}}, b};
      (size == SIZE_HALF):
        result = {{16{h[15] & ~unsignedLoad}}, h};
      default:
        result = word;
    endcase
  end

endmodule

// File: rtl/data_memory_be.sv
// Byte/half/word data memory with error flags and an
// optional post-reset clear sweep.
module data_memory_be
  import data_memory_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int DEPTH          = 128,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic [1:0]        size,
  input  logic              unsignedLoad,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              readValid,
  output logic              busy,
  output logic              misaligned,
  output logic              outOfRange
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem_q [DEPTH];

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, mis_q, oor_q;

  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  widx;
  logic [31:0]       idx_ext;
  logic [1:0]        off;
  logic              req, ready;
  logic              mis, oor, legal;
  logic [3:0]        be;
  logic [31:0]       lane, old_w, merged;

  assign idx     = address[ADDR_W-1:2];
  assign off     = address[1:0];
  assign widx    = idx[CNT_W-1:0];
  assign idx_ext = 32'(idx);
  assign req     = memRead | memWrite;
  assign ready   = (state_q == ST_READY);

  assign mis = (size == SIZE_HALF && off[0])
             || (size == SIZE_WORD && off != 2'b00)
             || (size == 2'b11);
  assign oor   = !mis && (idx_ext >= 32'(DEPTH));
  assign legal = ready && req && !mis && !oor;
  assign be    = byte_enable(size, off);

  always_comb begin
    lane = writeData;
    unique case (1'b1)
      (size == SIZE_BYTE): lane = {4{writeData[7:0]}};
      (size == SIZE_HALF): lane = {2{writeData[15:0]}};
      default:             lane = writeData;
    endcase
  end

  // Write-first: the load sees the merged word of a same-cycle store.
  assign old_w = mem_q[widx];
  always_comb begin
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (memWrite && be[i]) begin
        merged[8*i +: 8] = lane[8*i +: 8];
      end
    end
  end

  mem_load_align u_align (
    .word         (merged),
    .size         (size),
    .off          (off),
    .unsignedLoad (unsignedLoad),
    .result       (rdata_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_q[cnt_q] <= 32'h0;
      end else if (legal && memWrite) begin
        mem_q[widx] <= merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      cnt_q    <= '0;
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          cnt_q    <= cnt_q + 1'b1;
          rvalid_q <= 1'b0;
          mis_q    <= 1'b0;
          oor_q    <= 1'b0;
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_q <= ST_READY;
          end
        end
        default: begin
          rvalid_q <= legal && memRead;
          mis_q    <= req && mis;
          oor_q    <= req && oor;
          if (legal && memRead) begin
            rdata_q <= rdata_d;
          end
        end
      endcase
    end
  end

  assign readData   = rdata_q;
  assign readValid  = rvalid_q;
  assign busy       = (state_q == ST_CLEAR);
  assign misaligned = mis_q;
  assign outOfRange = oor_q;

endmodule
